rtermcal_ctrl: RTL and testbench

//  Digital calibration controller directly upstream of the RTERMCAL analog cell.
//  - Drives the cell's trim codes and mode, then reads its 2-bit comparator result.
//  - Finds the SGIO code with a linear thermometer sweep, then the LVDS code with a 4-bit SAR search.
//  - Holds the final codes for the IO ring and reports DONE/ERR to the IO config registers.

---
 rtl/rtermcal_pkg.sv | 27 ++
 rtl/rtermcal_vote.sv | 42 ++++
 rtl/rtermcal_ctrl.sv | 147 ++++++++++++++
 tb/tb_rtermcal_ctrl.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/rtermcal_pkg.sv
// Shared types and encodings for the RTERMCAL calibration controller.
// No logic; imported by the controller and its vote sub-module.
package rtermcal_pkg;

    localparam int SG_BITS = 15;
    localparam int LV_BITS = 4;
    localparam int SAMPLES = 3;

    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_SGIO = 2'b01;
    localparam logic [1:0] MODE_LVDS = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SG_SETTLE = 3'd1,
        ST_SG_SAMPLE = 3'd2,
        ST_LV_SETTLE = 3'd3,
        ST_LV_SAMPLE = 3'd4,
        ST_DONE      = 3'd5
    } state_t;

    // Thermometer code with the n lowest bits set.
    function automatic logic [SG_BITS-1:0] therm(input logic [3:0] n);
        return SG_BITS'((16'd1 << n) - 16'd1);
    endfunction

endpackage

// File: rtl/rtermcal_vote.sv
// Synchronises the cell comparator and takes a 3-sample majority vote.
// Latency: 2-cycle synchroniser; vote is combinational on the third captured sample.
// Backpressure: none; samples are taken whenever capture is high.
module rtermcal_vote
    import rtermcal_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] result,
    input  logic       sel,
    input  logic       clr,
    input  logic       capture,
    output logic       vote
);

    logic [1:0] sync1;
    logic [1:0] sync2;
    logic [SAMPLES-2:0] hist;
    logic       cur;

    assign cur = sel ? sync2[1] : sync2[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 2'b00;
            sync2 <= 2'b00;
            hist  <= '0;
        end else begin
            sync1 <= result;
            sync2 <= sync1;
            if (clr) begin
                hist <= '0;
            end else if (capture) begin
                hist <= {hist[0], cur};
            end
        end
    end

    // Two earlier samples are held; the third is the live synchronised bit.
    assign vote = (hist[1] & hist[0]) | (hist[1] & cur) | (hist[0] & cur);

endmodule

// File: rtl/rtermcal_ctrl.sv
// Calibrates RTERMCAL: linear SGIO thermometer sweep, then 4-bit LVDS SAR search.
// Latency: (SETTLE_CYCLES+3) cycles per step; DONE one cycle after the final decision.
// Backpressure: START ignored while busy; results held until the next accepted START.
module rtermcal_ctrl
    import rtermcal_pkg::*;
#(
    parameter int SETTLE_CYCLES = 32,
    parameter int SETTLE_W      = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [1:0]         result,
    output logic [1:0]         mode,
    output logic [SG_BITS:1]   d_iosg,
    output logic [LV_BITS-1:0] d_lvds,
    output logic [3:0]         code_sgio,
    output logic               busy,
    output logic               done,
    output logic [1:0]         err
);

    if (SETTLE_CYCLES < 3) begin : g_bad_settle
        $error("SETTLE_CYCLES must be at least 3 to flush the synchroniser");
    end
    if (SETTLE_CYCLES > (2 ** SETTLE_W)) begin : g_bad_settle_w
        $error("SETTLE_W too narrow for SETTLE_CYCLES");
    end

    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [1:0]          SAMP_LAST   = 2'(SAMPLES - 1);

    state_t              state;
    logic [SETTLE_W-1:0] settle_cnt;
    logic [1:0]          samp_cnt;
    logic [3:0]          k;
    logic [1:0]          sar_bit;
    logic                vote;
    logic                clr;
    logic                capture;
    logic [LV_BITS-1:0]  lv_kept;
    logic [LV_BITS-1:0]  lv_next;

    assign clr     = ((state == ST_SG_SETTLE) || (state == ST_LV_SETTLE)) && (settle_cnt == '0);
    assign capture = (state == ST_SG_SAMPLE) || (state == ST_LV_SAMPLE);

    rtermcal_vote u_vote (
        .clk     (clk),
        .rst_n   (rst_n),
        .result  (result),
        .sel     (state == ST_LV_SAMPLE),
        .clr     (clr),
        .capture (capture),
        .vote    (vote)
    );

    // A trip means the trial is too strong: drop the bit, then try the next lower one.
    always_comb begin
        lv_kept = vote ? (d_lvds & ~(4'b0001 << sar_bit)) : d_lvds;
        lv_next = lv_kept;
        if (sar_bit != 2'd0) begin
            lv_next = lv_kept | (4'b0001 << (sar_bit - 2'd1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            settle_cnt <= '0;
            samp_cnt   <= 2'd0;
            k          <= 4'd0;
            sar_bit    <= 2'd0;
            mode       <= MODE_OFF;
            d_iosg     <= '0;
            d_lvds     <= '0;
            code_sgio  <= 4'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 2'b00;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start && !busy) begin
                        state      <= ST_SG_SETTLE;
                        settle_cnt <= SETTLE_LOAD;
                        k          <= 4'd0;
                        d_iosg     <= '0;
                        mode       <= MODE_SGIO;
                        d_lvds     <= '0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        err        <= 2'b00;
                    end else if (state == ST_DONE) begin
                        mode <= MODE_OFF;
                        busy <= 1'b0;
                        done <= 1'b1;
                    end
                end
                ST_SG_SETTLE, ST_LV_SETTLE: begin
                    if (settle_cnt == '0) begin
                        state    <= (state == ST_SG_SETTLE) ? ST_SG_SAMPLE : ST_LV_SAMPLE;
                        samp_cnt <= 2'd0;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                ST_SG_SAMPLE: begin
                    if (samp_cnt == SAMP_LAST) begin
                        if (!vote && (k != 4'd15)) begin
                            k          <= k + 4'd1;
                            d_iosg     <= therm(k + 4'd1);
                            settle_cnt <= SETTLE_LOAD;
                            state      <= ST_SG_SETTLE;
                        end else begin
                            code_sgio  <= k;
                            err[0]     <= !vote;
                            mode       <= MODE_LVDS;
                            d_lvds     <= 4'b1000;
                            sar_bit    <= 2'd3;
                            settle_cnt <= SETTLE_LOAD;
                            state      <= ST_LV_SETTLE;
                        end
                    end else begin
                        samp_cnt <= samp_cnt + 2'd1;
                    end
                end
                ST_LV_SAMPLE: begin
                    if (samp_cnt == SAMP_LAST) begin
                        d_lvds <= lv_next;
                        if (sar_bit == 2'd0) begin
                            err[1] <= (lv_next == '0);
                            state  <= ST_DONE;
                        end else begin
                            sar_bit    <= sar_bit - 2'd1;
                            settle_cnt <= SETTLE_LOAD;
                            state      <= ST_LV_SETTLE;
                        end
                    end else begin
                        samp_cnt <= samp_cnt + 2'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rtermcal_ctrl.sv
// Directed bench for rtermcal_ctrl driven by a behavioural RTERMCAL cell model.
module tb_rtermcal_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  result;
    logic [1:0]  mode;
    logic [15:1] d_iosg;
    logic [3:0]  d_lvds;
    logic [3:0]  code_sgio;
    logic        busy;
    logic        done;
    logic [1:0]  err;

    int total = 0;
    int passed = 0;
    int rext = 200;
    bit glitch = 1'b0;

    always #5 clk = ~clk;

    rtermcal_ctrl #(.SETTLE_CYCLES(32), .SETTLE_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .result    (result),
        .mode      (mode),
        .d_iosg    (d_iosg),
        .d_lvds    (d_lvds),
        .code_sgio (code_sgio),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    // Cell: sg = 20+5000/(17+k), lv = -10+5000/(17+c); comparator trips below R_ext.
    int sg_r;
    int lv_r;
    logic [1:0] res_m;
    always_comb begin
        sg_r  = 20 + 5000 / (17 + $countones(d_iosg));
        lv_r  = -10 + 5000 / (17 + int'(d_lvds));
        res_m = 2'b00;
        if (mode == 2'b01 && sg_r < rext) res_m[0] = 1'b1;
        if (mode == 2'b10 && lv_r < rext) res_m[1] = 1'b1;
        if (glitch) res_m = res_m ^ mode;
        result = res_m;
    end

    typedef struct {
        int          rext;
        bit          glitch;
        int          mid;
        logic [3:0]  code;
        logic [14:0] iosg;
        logic [3:0]  lvds;
        logic [1:0]  err;
        int          lat;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic run_cal(input int idx);
        vec_t v;
        int cur;
        int lat;
        v = vecs[idx];
        rext = v.rext;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk($sformatf("v%0d accept done", idx), 32'(done), 32'd0);
        chk($sformatf("v%0d accept err", idx), 32'(err), 32'd0);
        chk($sformatf("v%0d accept busy", idx), 32'(busy), 32'd1);
        chk($sformatf("v%0d accept mode", idx), 32'(mode), 32'd1);
        cur = 0;
        lat = 0;
        while (cur < 2000 && lat == 0) begin
            // One-cycle glitch lands on the middle of each 3-sample window.
            glitch = v.glitch && ((cur % 35) == 31);
            start  = (v.mid != 0) && (cur == v.mid);
            @(posedge clk); #1;
            cur++;
            if (done) lat = cur;
        end
        glitch = 1'b0;
        start  = 1'b0;
        chk($sformatf("v%0d latency", idx), 32'(lat), 32'(v.lat));
        chk($sformatf("v%0d code_sgio", idx), 32'(code_sgio), 32'(v.code));
        chk($sformatf("v%0d d_iosg", idx), 32'(d_iosg), 32'(v.iosg));
        chk($sformatf("v%0d d_lvds", idx), 32'(d_lvds), 32'(v.lvds));
        chk($sformatf("v%0d err", idx), 32'(err), 32'(v.err));
        chk($sformatf("v%0d busy", idx), 32'(busy), 32'd0);
        chk($sformatf("v%0d mode", idx), 32'(mode), 32'd0);
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, " mode"}, 32'(mode), 32'd0);
        chk({nm, " d_iosg"}, 32'(d_iosg), 32'd0);
        chk({nm, " d_lvds"}, 32'(d_lvds), 32'd0);
        chk({nm, " code_sgio"}, 32'(code_sgio), 32'd0);
        chk({nm, " busy"}, 32'(busy), 32'd0);
        chk({nm, " done"}, 32'(done), 32'd0);
        chk({nm, " err"}, 32'(err), 32'd0);
    endtask

    initial begin
        // Nominal: trip at k=11 (198<200); SAR 8 trips, 4 keeps, 6 keeps, 7 trips -> 6.
        vecs[0] = '{rext:200,  glitch:1'b0, mid:0,   code:4'd11, iosg:15'h07FF, lvds:4'd6,  err:2'b00, lat:561};
        // R_ext below every model value: nothing ever trips.
        vecs[1] = '{rext:10,   glitch:1'b0, mid:0,   code:4'd15, iosg:15'h7FFF, lvds:4'd15, err:2'b01, lat:701};
        // R_ext above every model value: every trial trips.
        vecs[2] = '{rext:1000, glitch:1'b0, mid:0,   code:4'd0,  iosg:15'h0000, lvds:4'd0,  err:2'b10, lat:176};
        vecs[3] = '{rext:200,  glitch:1'b1, mid:0,   code:4'd11, iosg:15'h07FF, lvds:4'd6,  err:2'b00, lat:561};
        vecs[4] = '{rext:200,  glitch:1'b0, mid:100, code:4'd11, iosg:15'h07FF, lvds:4'd6,  err:2'b00, lat:561};

        #1;
        chk_reset("reset");
        #20 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("idle busy", 32'(busy), 32'd0);

        for (int i = 0; i < 5; i++) begin
            run_cal(i);
            repeat (2) @(posedge clk);
            #1 chk($sformatf("v%0d done held", i), 32'(done), 32'd1);
        end

        // Asynchronous reset while the LVDS search is running.
        rext = 200;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (480) @(posedge clk);
        #1 chk("pre-reset mode lvds", 32'(mode), 32'd2);
        #2 rst_n = 1'b0;
        #1 chk_reset("mid reset");
        @(negedge clk) rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1 chk("post reset stays idle", 32'(busy), 32'd0);
        chk("post reset mode", 32'(mode), 32'd0);

        run_cal(0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
